// File: rtl/adder_bist_pkg.sv
// adder_bist_pkg: shared types, sizes and golden full-adder model
// for the full-adder self-test block.
package adder_bist_pkg;

  localparam int VEC_W       = 3;
  localparam int NUM_VEC     = 8;
  localparam int ERR_W       = 4;
  localparam int MAX_LATENCY = 3;
  localparam int PCNT_W      = 4;
  localparam int DCNT_W      = $clog2(MAX_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DRAIN,
    DONE
  } state_t;

  typedef logic [VEC_W-1:0] vec_t;

  // Vector is {a,b,cin}; result is {sum,cout}.
  function automatic logic [1:0] golden(
    input vec_t v
  );
    logic a;
    logic b;
    logic c;
    {a, b, c} = v;
    return {a ^ b ^ c, (a & b) | (a & c) | (b & c)};
  endfunction

endpackage

// File: rtl/adder_bist_if.sv
// adder_bist_if: stimulus, result and status bundle between the
// self-test block (master) and its adder/host side (slave).
interface adder_bist_if;
  import adder_bist_pkg::*;

  logic               start;
  logic               stim_a;
  logic               stim_b;
  logic               stim_cin;
  logic               dut_sum;
  logic               dut_cout;
  logic               busy;
  logic               done;
  logic               pass;
  logic [ERR_W-1:0]   err_count;
  logic [NUM_VEC-1:0] fail_vec;

  modport master (
    input  start,
    input  dut_sum,
    input  dut_cout,
    output stim_a,
    output stim_b,
    output stim_cin,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_vec
  );

  modport slave (
    output start,
    output dut_sum,
    output dut_cout,
    input  stim_a,
    input  stim_b,
    input  stim_cin,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_vec
  );

endinterface

// File: rtl/adder_bist_ref.sv
// adder_bist_ref: golden model behind a vector/valid delay line so
// expected results line up with a LATENCY-cycle adder.
// Ports: clk, rst (sync, high), flush (drop in-flight tags),
//   in_vec/in_valid (driven vector), exp_sc ({sum,cout} expected),
//   out_vec/out_valid (vector tag emerging after LATENCY cycles).
module adder_bist_ref
  import adder_bist_pkg::*;
#(
  parameter int LATENCY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  vec_t       in_vec,
  input  logic       in_valid,
  output logic [1:0] exp_sc,
  output vec_t       out_vec,
  output logic       out_valid
);

  generate
    if (LATENCY == 0) begin : g_comb
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst};
      assign out_vec   = in_vec;
      assign out_valid = in_valid & ~flush;
    end else begin : g_pipe
      vec_t               vec_q [LATENCY];
      logic [LATENCY-1:0] val_q;

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          val_q <= '0;
        end else begin
          val_q[0] <= in_valid;
          for (int i = 1; i < LATENCY; i++) begin
            val_q[i] <= val_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        vec_q[0] <= in_vec;
        for (int i = 1; i < LATENCY; i++) begin
          vec_q[i] <= vec_q[i-1];
        end
      end

      assign out_vec   = vec_q[LATENCY-1];
      assign out_valid = val_q[LATENCY-1];
    end
  endgenerate

  assign exp_sc = golden(out_vec);

endmodule

// File: rtl/adder_bist.sv
// adder_bist: exhaustive self-test initiator for a 1-bit full adder.
// Sweeps {a,b,cin}, checks {sum,cout}, reports errors per vector.
// Ports: clk, rst (sync, high); bus (master): start, stim_a/b/cin,
//   dut_sum/cout, busy, done, pass, err_count, fail_vec.
// Params: DUT_LATENCY (0..3), PASSES (1..15).
// Option: ADDER_BIST_STOP_ON_FAIL_EN ends the run at first mismatch.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int DUT_LATENCY = 0,
  parameter int PASSES      = 1
) (
  input  logic        clk,
  input  logic        rst,
  adder_bist_if.master bus
);

  state_t             state_q;
  state_t             state_d;
  vec_t               vec_q;
  logic [PCNT_W-1:0]  pcnt_q;
  logic [DCNT_W-1:0]  dcnt_q;
  logic [ERR_W-1:0]   err_q;
  logic [NUM_VEC-1:0] fail_q;
  logic               done_q;

  logic       busy;
  logic       drive;
  logic       idle_like;
  logic       start_ok;
  logic       vec_wrap;
  logic       last_vec;
  logic       drain_end;
  logic [1:0] exp_sc;
  vec_t       cmp_vec;
  logic       cmp_valid;
  logic       mism;

  assign drive     = state_q == DRIVE;
  assign busy      = drive || (state_q == DRAIN);
  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign start_ok  = bus.start && idle_like;
  assign vec_wrap  = vec_q == VEC_W'(NUM_VEC - 1);
  assign last_vec  = vec_wrap && (pcnt_q == PCNT_W'(PASSES - 1));
  assign drain_end = dcnt_q == DCNT_W'(DUT_LATENCY - 1);

  adder_bist_ref #(
    .LATENCY (DUT_LATENCY)
  ) u_ref (
    .clk       (clk),
    .rst       (rst),
    .flush     (idle_like),
    .in_vec    (vec_q),
    .in_valid  (drive),
    .exp_sc    (exp_sc),
    .out_vec   (cmp_vec),
    .out_valid (cmp_valid)
  );

  // Tags still in flight after an early stop land in DONE
  // and are ignored by the busy gate.
  assign mism = cmp_valid && busy
             && ({bus.dut_sum, bus.dut_cout} != exp_sc);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = DRIVE;
      end
      DRIVE: begin
        if (last_vec) begin
          state_d = (DUT_LATENCY == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (drain_end) state_d = DONE;
      end
      DONE: begin
        if (bus.start) state_d = DRIVE;
      end
      default: state_d = IDLE;
    endcase
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    if (mism) state_d = DONE;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      pcnt_q  <= '0;
      dcnt_q  <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        vec_q  <= '0;
        pcnt_q <= '0;
        dcnt_q <= '0;
        err_q  <= '0;
        fail_q <= '0;
        done_q <= 1'b0;
      end else begin
        if (drive) begin
          vec_q <= vec_q + 1'b1;
          if (vec_wrap) pcnt_q <= pcnt_q + 1'b1;
        end
        if (state_q == DRAIN) begin
          dcnt_q <= dcnt_q + 1'b1;
        end else begin
          dcnt_q <= '0;
        end
        if (mism) begin
          if (err_q != '1) err_q <= err_q + 1'b1;
          fail_q[cmp_vec] <= 1'b1;
        end
        // done trails the DONE state by one edge and is sticky.
        if (state_q == DONE) done_q <= 1'b1;
      end
    end
  end

  assign {bus.stim_a, bus.stim_b, bus.stim_cin} = drive ? vec_q : '0;

  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.pass      = done_q && (err_q == '0);
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_q;

endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: directed checks of adder_bist against good and
// faulty adders at latency 0 and 2 and with multiple passes.
module tb_adder_bist;

  logic clk;
  logic rst;
  logic [2:0] fault0;
  logic [2:0] fault2;
  logic [1:0] r1;
  logic [1:0] r2;
  int n_checks;
  int n_errors;

  adder_bist_if if0();
  adder_bist_if if1();
  adder_bist_if if2();

  adder_bist #(.DUT_LATENCY(0), .PASSES(1)) u_dut0 (
    .clk (clk), .rst (rst), .bus (if0)
  );
  adder_bist #(.DUT_LATENCY(2), .PASSES(1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (if1)
  );
  adder_bist #(.DUT_LATENCY(0), .PASSES(3)) u_dut2 (
    .clk (clk), .rst (rst), .bus (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder under test with an injectable fault:
  // 1 sum stuck-0, 2 cout stuck-1, 3 sum inverted.
  function automatic logic [1:0] fadd(
    input logic [2:0] f,
    input logic [2:0] v
  );
    logic s;
    logic c;
    s = v[2] ^ v[1] ^ v[0];
    c = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    case (f)
      3'd1: s = 1'b0;
      3'd2: c = 1'b1;
      3'd3: s = ~s;
      default: ;
    endcase
    return {s, c};
  endfunction

  assign {if0.dut_sum, if0.dut_cout} =
    fadd(fault0, {if0.stim_a, if0.stim_b, if0.stim_cin});
  assign {if2.dut_sum, if2.dut_cout} =
    fadd(fault2, {if2.stim_a, if2.stim_b, if2.stim_cin});

  always @(posedge clk) begin
    r1 <= fadd(3'd0, {if1.stim_a, if1.stim_b, if1.stim_cin});
    r2 <= r1;
  end
  assign {if1.dut_sum, if1.dut_cout} = r2;

  task automatic check(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    fault0 = 3'd0;
    fault2 = 3'd0;
    if0.start = 1'b0;
    if1.start = 1'b0;
    if2.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_busy", 8'(if0.busy), 8'd0);
    check("rst_done", 8'(if0.done), 8'd0);
    check("rst_pass", 8'(if0.pass), 8'd0);
    check("rst_err", 8'(if0.err_count), 8'd0);
    check("rst_fail", if0.fail_vec, 8'h00);
    check("rst_stim",
      8'({if0.stim_a, if0.stim_b, if0.stim_cin}), 8'd0);
    check("rst_busy1", 8'(if1.busy), 8'd0);

    // good adder, L=0: stim 0..7, done at edge 9
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("l0_stim",
        8'({if0.stim_a, if0.stim_b, if0.stim_cin}), 8'(i));
      check("l0_busy", 8'(if0.busy), 8'd1);
      @(negedge clk);
    end
    check("l0_done_e8", 8'(if0.done), 8'd0);
    check("l0_busy_e8", 8'(if0.busy), 8'd0);
    @(negedge clk);
    check("l0_done_e9", 8'(if0.done), 8'd1);
    check("l0_pass", 8'(if0.pass), 8'd1);
    check("l0_err", 8'(if0.err_count), 8'd0);
    check("l0_fail", if0.fail_vec, 8'h00);

    // sum stuck-0, restarted from DONE
    fault0 = 3'd1;
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    check("s0_done_clr", 8'(if0.done), 8'd0);
    repeat (9) @(negedge clk);
    check("s0_done", 8'(if0.done), 8'd1);
    check("s0_err", 8'(if0.err_count), 8'd4);
    check("s0_fail", if0.fail_vec, 8'h96);
    check("s0_pass", 8'(if0.pass), 8'd0);

    // cout stuck-1
    fault0 = 3'd2;
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (9) @(negedge clk);
    check("c1_err", 8'(if0.err_count), 8'd4);
    check("c1_fail", if0.fail_vec, 8'h17);
    check("c1_pass", 8'(if0.pass), 8'd0);

    // reset mid-run at vec=5
    fault0 = 3'd1;
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (5) @(negedge clk);
    check("mr_stim5",
      8'({if0.stim_a, if0.stim_b, if0.stim_cin}), 8'd5);
    check("mr_err_pre", 8'(if0.err_count), 8'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_busy", 8'(if0.busy), 8'd0);
    check("mr_done", 8'(if0.done), 8'd0);
    check("mr_err", 8'(if0.err_count), 8'd0);
    check("mr_fail", if0.fail_vec, 8'h00);
    check("mr_stim",
      8'({if0.stim_a, if0.stim_b, if0.stim_cin}), 8'd0);
    repeat (10) @(negedge clk);
    check("mr_done_late", 8'(if0.done), 8'd0);
    fault0 = 3'd0;
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (9) @(negedge clk);
    check("mr_rerun_done", 8'(if0.done), 8'd1);
    check("mr_rerun_pass", 8'(if0.pass), 8'd1);
    check("mr_rerun_fail", if0.fail_vec, 8'h00);

    // L=2 registered adder; extra start at edge 4 is ignored
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("l2_busy", 8'(if1.busy), 8'd1);
      check("l2_stim",
        8'({if1.stim_a, if1.stim_b, if1.stim_cin}),
        (i < 8) ? 8'(i) : 8'd0);
      if1.start = (i == 3);
      @(negedge clk);
    end
    check("l2_busy_e10", 8'(if1.busy), 8'd0);
    check("l2_done_e10", 8'(if1.done), 8'd0);
    @(negedge clk);
    check("l2_done_e11", 8'(if1.done), 8'd1);
    check("l2_pass", 8'(if1.pass), 8'd1);
    check("l2_err", 8'(if1.err_count), 8'd0);

    // PASSES=3, cout stuck-1: done at edge 25
    fault2 = 3'd2;
    if2.start = 1'b1;
    @(negedge clk);
    if2.start = 1'b0;
    repeat (24) @(negedge clk);
    check("p3_done_e24", 8'(if2.done), 8'd0);
    @(negedge clk);
    check("p3_done_e25", 8'(if2.done), 8'd1);
    check("p3_err", 8'(if2.err_count), 8'd12);
    check("p3_fail", if2.fail_vec, 8'h17);

    // PASSES=3, sum inverted: 24 mismatches saturate at 15
    fault2 = 3'd3;
    if2.start = 1'b1;
    @(negedge clk);
    if2.start = 1'b0;
    repeat (25) @(negedge clk);
    check("sat_err", 8'(if2.err_count), 8'd15);
    check("sat_fail", if2.fail_vec, 8'hff);
    check("sat_pass", 8'(if2.pass), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors",
      n_checks, n_errors);
    $finish;
  end

endmodule
